// File: rtl/dds_interp_pkg.sv
// Shared state encoding and default widths for the linear-interpolating DDS upsampler.
package dds_interp_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_OUT_W    = 12;
   localparam int DEF_MAX_LOG2 = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/dds_interp_lin.sv
// Linear interpolator: emits 2^k points per input pair, first output one cycle after the second sample.
// m_ready low freezes the segment; s_ready only opens on the last step of a segment (gapless reload).
module dds_interp_lin
   import dds_interp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int OUT_W    = DEF_OUT_W,
   parameter int MAX_LOG2 = DEF_MAX_LOG2
)(
   input  logic                           Fg_CLK,
   input  logic                           RESETn,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_W-1:0]              s_data,
   input  logic [$clog2(MAX_LOG2+1)-1:0]  ratio_log2,
   input  logic                           flush,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [OUT_W-1:0]               m_data
);

   localparam int ACC_W = DATA_W + MAX_LOG2 + 1;
   localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
   localparam int KW    = $clog2(MAX_LOG2 + 1);

   state_t                  state, state_nxt;
   logic [DATA_W-1:0]       prev, cur;
   logic signed [ACC_W-1:0] acc;
   logic signed [DATA_W:0]  diff;
   logic [CNT_W-1:0]        cnt;
   logic [KW-1:0]           k_lat;

   logic [KW-1:0]           k_in;
   logic [CNT_W:0]          seg_len;
   logic                    cnt_last;
   logic                    cap_first, do_load, m_step;
   logic signed [ACC_W-1:0] acc_sh;
   logic                    unused_ok;

   assign k_in     = (ratio_log2 > KW'(MAX_LOG2)) ? KW'(MAX_LOG2) : ratio_log2;
   assign seg_len  = (CNT_W+1)'(1) << k_lat;
   assign cnt_last = ({1'b0, cnt} == seg_len - (CNT_W+1)'(1));

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      cap_first = 1'b0;
      do_load   = 1'b0;
      m_step    = 1'b0;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               cap_first = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               do_load   = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            m_valid = 1'b1;
            s_ready = cnt_last && m_ready;
            m_step  = m_ready;
            if (m_ready && cnt_last) begin
               if (s_valid) do_load   = 1'b1;
               else         state_nxt = LOAD;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // flush overrides every event, including a simultaneous sample
      if (flush) begin
         state_nxt = IDLE;
         cap_first = 1'b0;
         do_load   = 1'b0;
         m_step    = 1'b0;
      end
      if (!RESETn) s_ready = 1'b0;
   end

   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         prev  <= '0;
         cur   <= '0;
         acc   <= '0;
         diff  <= '0;
         cnt   <= '0;
         k_lat <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (cap_first) begin
         cur <= s_data;
      end else if (do_load) begin
         prev  <= cur;
         cur   <= s_data;
         k_lat <= k_in;
         acc   <= {{(MAX_LOG2+1){cur[DATA_W-1]}}, cur} << k_in;
         diff  <= {s_data[DATA_W-1], s_data} - {cur[DATA_W-1], cur};
         cnt   <= '0;
      end else if (m_step) begin
         // exact running sum: acc = prev*2^k + i*diff, divided only at the output
         acc <= acc + ACC_W'(diff);
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign acc_sh    = acc >>> k_lat;
   assign m_data    = acc_sh[DATA_W-1 -: OUT_W];
   assign unused_ok = ^{acc_sh, prev};

endmodule

// File: tb/tb_dds_interp_lin.sv
// Randomized and directed bench for dds_interp_lin against a segment-level interpolation model.
module tb_dds_interp_lin;

   localparam int DATA_W   = 32;
   localparam int OUT_W    = 12;
   localparam int MAX_LOG2 = 4;
   localparam int KW       = $clog2(MAX_LOG2 + 1);

   logic              Fg_CLK     = 1'b0;
   logic              RESETn     = 1'b0;
   logic              s_valid    = 1'b0;
   logic              flush      = 1'b0;
   logic              m_ready    = 1'b1;
   logic [DATA_W-1:0] s_data     = '0;
   logic [KW-1:0]     ratio_log2 = '0;
   logic              s_ready, m_valid;
   logic [OUT_W-1:0]  m_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [OUT_W-1:0] exp_q[$];
   logic [OUT_W-1:0] obs_q[$];
   logic [OUT_W-1:0] want[$];
   bit               have_cur = 1'b0;
   longint           cur_v    = 0;
   bit               exp_srdy;

   always #5 Fg_CLK = ~Fg_CLK;

   dds_interp_lin #(
      .DATA_W   (DATA_W),
      .OUT_W    (OUT_W),
      .MAX_LOG2 (MAX_LOG2)
   ) dut (
      .Fg_CLK     (Fg_CLK),
      .RESETn     (RESETn),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .ratio_log2 (ratio_log2),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One interpolation segment from p to c: 2^k points p + i*(c-p)/2^k, floored, top OUT_W bits.
   task automatic model_accept(input logic [DATA_W-1:0] d, input int r);
      longint           nv, v;
      logic [63:0]      t;
      int               k;
      k  = (r > MAX_LOG2) ? MAX_LOG2 : r;
      nv = longint'($signed(d));
      if (have_cur) begin
         for (int i = 0; i < (1 << k); i++) begin
            v = ((cur_v * (64'sd1 << k)) + longint'(i) * (nv - cur_v)) >>> k;
            t = v;
            exp_q.push_back(t[DATA_W-1 -: OUT_W]);
         end
      end
      cur_v    = nv;
      have_cur = 1'b1;
   endtask

   always @(negedge Fg_CLK) begin
      if (!RESETn) begin
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_data",  m_data,  0);
         chk("rst_s_ready", s_ready, 0);
         exp_q.delete();
         have_cur = 1'b0;
      end else begin
         exp_srdy = (exp_q.size() == 0) || (exp_q.size() == 1 && m_ready);
         chk("m_valid", m_valid, exp_q.size() != 0);
         chk("s_ready", s_ready, exp_srdy);
         if (exp_q.size() != 0) chk("m_data", m_data, exp_q[0]);
         if (flush) begin
            exp_q.delete();
            have_cur = 1'b0;
         end else begin
            if (exp_q.size() != 0 && m_ready) begin
               obs_q.push_back(m_data);
               void'(exp_q.pop_front());
            end
            if (s_valid && exp_srdy) model_accept(s_data, int'(ratio_log2));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge Fg_CLK);
      #1;
   endtask

   task automatic put(input logic [DATA_W-1:0] d);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      for (int t = 0; t < 200; t++) begin
         @(negedge Fg_CLK);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("put_accepted", ok, 1);
      step(1);
      s_valid = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
   endtask

   task automatic check_obs(input string tag);
      chk({tag, "_count"}, obs_q.size(), want.size());
      for (int i = 0; i < want.size() && i < obs_q.size(); i++)
         chk($sformatf("%s_%0d", tag, i), obs_q[i], want[i]);
      obs_q.delete();
   endtask

   initial begin
      logic [DATA_W-1:0] a, b, c;

      step(3);
      RESETn = 1'b1;
      step(1);

      // rising ramp, k=2
      obs_q.delete();
      ratio_log2 = 3'd2;
      put(32'h0000_0000);
      put(32'h1000_0000);
      step(8);
      want = {12'h000, 12'h040, 12'h080, 12'h0C0};
      check_obs("ramp");

      // falling then rising, gapless reload
      do_flush();
      obs_q.delete();
      put(32'h1000_0000);
      put(32'h0000_0000);
      put(32'h1000_0000);
      step(8);
      want = {12'h100, 12'h0C0, 12'h080, 12'h040, 12'h000, 12'h040, 12'h080, 12'h0C0};
      check_obs("gapless");

      // backpressure mid-segment
      do_flush();
      obs_q.delete();
      put(32'h0000_0000);
      put(32'h1000_0000);
      step(1);
      m_ready = 1'b0;
      step(3);
      m_ready = 1'b1;
      step(8);
      want = {12'h000, 12'h040, 12'h080, 12'h0C0};
      check_obs("bp");

      // ratio clamp 7 -> 4, mid-segment change ignored
      do_flush();
      obs_q.delete();
      ratio_log2 = 3'd7;
      put(32'h0000_0000);
      put(32'h1000_0000);
      ratio_log2 = 3'd1;
      step(24);
      want.delete();
      for (int i = 0; i < 16; i++) want.push_back(12'(i * 16));
      check_obs("clamp");

      // k=0 passthrough
      do_flush();
      obs_q.delete();
      ratio_log2 = 3'd0;
      a = $urandom;
      b = $urandom;
      c = $urandom;
      put(a);
      put(b);
      put(c);
      step(4);
      want = {a[31:20], b[31:20]};
      check_obs("k0");

      // reset mid-segment, k=3
      do_flush();
      ratio_log2 = 3'd3;
      put(32'h0000_0000);
      put(32'h1000_0000);
      step(2);
      RESETn = 1'b0;
      step(2);
      RESETn = 1'b1;
      step(10);
      obs_q.delete();

      // flush with a simultaneous sample drops it
      ratio_log2 = 3'd2;
      put(32'h0000_0000);
      s_valid = 1'b1;
      s_data  = 32'h7000_0000;
      do_flush();
      s_valid = 1'b0;
      put(32'h1000_0000);
      step(5);
      want.delete();
      check_obs("flush");

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         s_valid    = $urandom_range(0, 1);
         s_data     = $urandom;
         m_ready    = ($urandom_range(0, 3) != 0);
         ratio_log2 = KW'($urandom_range(0, 7));
         flush      = ($urandom_range(0, 199) == 0);
         step(1);
      end
      s_valid = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b1;
      step(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
